// File: rtl/rotary_array.sv
// Multi-channel T-phase rotary encoder front end: input sync, glitch rejection,
// fast/slow step commit, velocity-dependent step size and host preload.
module rotary_array #(
  parameter int CH       = 2,
  parameter int N        = 12,
  parameter int INIT     = 0,
  parameter int SAT      = 1,
  parameter int T        = 3,
  parameter int DEB      = 200000,
  parameter int ACC_WIN  = 0,
  parameter int ACC_STEP = 4,
  localparam int W  = $clog2(N),
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CH*T-1:0] rot_ni,
  input  logic            ld_i,
  input  logic [CW-1:0]   ld_ch_i,
  input  logic [W-1:0]    ld_val_i,
  output logic [CH*W-1:0] counter_o,
  output logic [CH-1:0]   inc_o,
  output logic [CH-1:0]   dec_o
);

  localparam int          WP    = W + 1;
  localparam logic [W:0]  N_MAX = WP'(N - 1);
  localparam logic [W:0]  N_W   = WP'(N);
  localparam logic [W:0]  K_ACC = WP'(ACC_STEP);
  localparam logic [W:0]  K_ONE = WP'(1);
  localparam logic [31:0] DEB_W = 32'(DEB);
  localparam logic [31:0] WIN_W = 32'(ACC_WIN);

  function automatic logic [T-1:0] rot_r(input logic [T-1:0] x);
    return {x[0], x[T-1:1]};
  endfunction

  function automatic logic [T-1:0] rot_l(input logic [T-1:0] x);
    return {x[T-2:0], x[T-1]};
  endfunction

  logic [CH*T-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= rot_ni;
      sync2_q <= sync1_q;
    end
  end

  // mode  | meaning
  // IDLE  | cur == ref: settled, waiting for a non-idle pattern
  // TRACK | cur != ref: new pattern seen, fast commit or debounce pending
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [T-1:0] s, cur_q, cur_d, ref_q, ref_d;
    logic [31:0]  tmr_q, tmr_d, gap_q, gap_d;
    logic         dir_q, dir_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         inc_q, inc_d, dec_q, dec_d;
    logic         fwd, bwd, ld_hit;
    logic [W:0]   v, k, up_v, dn_v, ld_v;

    assign s = sync2_q[c*T +: T];

    always_comb begin
      cur_d  = cur_q;
      ref_d  = ref_q;
      tmr_d  = tmr_q;
      fwd    = 1'b0;
      bwd    = 1'b0;
      if (cur_q == ref_q) begin
        if (s != '1) begin
          cur_d = s;
          tmr_d = '0;
        end
      end else if (s != cur_q) begin
        cur_d = s;
        tmr_d = '0;
        if (cur_q == rot_r(ref_q) && s == rot_r(cur_q)) begin
          fwd   = 1'b1;
          ref_d = cur_q;
        end else if (cur_q == rot_l(ref_q) && s == rot_l(cur_q)) begin
          bwd   = 1'b1;
          ref_d = cur_q;
        end
      end else if (tmr_q < DEB_W) begin
        tmr_d = tmr_q + 32'd1;
      end else begin
        // debounce expiry: adopt the pattern, step only if it is a neighbour
        tmr_d = '0;
        ref_d = cur_q;
        fwd   = (cur_q == rot_r(ref_q));
        bwd   = !fwd && (cur_q == rot_l(ref_q));
      end

      v = {1'b0, cnt_q};
      k = (ACC_WIN > 0 && gap_q < WIN_W && fwd == dir_q) ? K_ACC : K_ONE;
      up_v = v + k;
      if (SAT != 0) begin
        if (up_v > N_MAX) up_v = N_MAX;
      end else if (up_v >= N_W) begin
        up_v = up_v - N_W;
      end
      if (v < k) dn_v = (SAT != 0) ? '0 : v + N_W - k;
      else       dn_v = v - k;

      ld_hit = ld_i && (ld_ch_i == CW'(c));
      ld_v   = ({1'b0, ld_val_i} >= N_W) ? N_MAX : {1'b0, ld_val_i};

      cnt_d = cnt_q;
      if (ld_hit)   cnt_d = ld_v[W-1:0];
      else if (fwd) cnt_d = up_v[W-1:0];
      else if (bwd) cnt_d = dn_v[W-1:0];

      inc_d = fwd && !ld_hit;
      dec_d = bwd && !ld_hit;
      dir_d = (fwd || bwd) ? fwd : dir_q;
      if (fwd || bwd)         gap_d = '0;
      else if (gap_q < WIN_W) gap_d = gap_q + 32'd1;
      else                    gap_d = gap_q;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cur_q <= '1;
        ref_q <= '1;
        tmr_q <= '0;
        gap_q <= WIN_W;
        dir_q <= 1'b0;
        cnt_q <= W'(INIT);
        inc_q <= 1'b0;
        dec_q <= 1'b0;
      end else begin
        cur_q <= cur_d;
        ref_q <= ref_d;
        tmr_q <= tmr_d;
        gap_q <= gap_d;
        dir_q <= dir_d;
        cnt_q <= cnt_d;
        inc_q <= inc_d;
        dec_q <= dec_d;
      end
    end

    assign counter_o[c*W +: W] = cnt_q;
    assign inc_o[c]            = inc_q;
    assign dec_o[c]            = dec_q;
  end

endmodule

// File: tb/tb_rotary_array.sv
// Scoreboard bench for rotary_array: three instances (saturate, wrap, accelerate)
// driven by directed phase sequences; a monitor checks every step pulse.
module tb_rotary_array;
  localparam int CH = 2;
  localparam int T  = 3;
  localparam int W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [CH*T-1:0] rot    [3];
  logic            ld     [3];
  logic [0:0]      ld_ch  [3];
  logic [W-1:0]    ld_val [3];
  logic [CH*W-1:0] cnt    [3];
  logic [CH-1:0]   inc    [3];
  logic [CH-1:0]   dec    [3];

  rotary_array #(.CH(2), .N(12), .INIT(0), .SAT(1), .T(3), .DEB(8), .ACC_WIN(0), .ACC_STEP(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .rot_ni(rot[0]), .ld_i(ld[0]), .ld_ch_i(ld_ch[0]),
    .ld_val_i(ld_val[0]), .counter_o(cnt[0]), .inc_o(inc[0]), .dec_o(dec[0]));

  rotary_array #(.CH(2), .N(12), .INIT(0), .SAT(0), .T(3), .DEB(8), .ACC_WIN(0), .ACC_STEP(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .rot_ni(rot[1]), .ld_i(ld[1]), .ld_ch_i(ld_ch[1]),
    .ld_val_i(ld_val[1]), .counter_o(cnt[1]), .inc_o(inc[1]), .dec_o(dec[1]));

  rotary_array #(.CH(2), .N(12), .INIT(0), .SAT(1), .T(3), .DEB(8), .ACC_WIN(16), .ACC_STEP(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .rot_ni(rot[2]), .ld_i(ld[2]), .ld_ch_i(ld_ch[2]),
    .ld_val_i(ld_val[2]), .counter_o(cnt[2]), .inc_o(inc[2]), .dec_o(dec[2]));

  typedef struct {
    int d;
    int ch;
    bit up;
    int val;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic push(input int d, input int c, input bit up, input int v);
    exp_t e;
    e.d = d; e.ch = c; e.up = up; e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk_cnt(input int d, input int c, input int v, input string name);
    check(name, int'(cnt[d][c*W +: W]), v);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int d, input logic [1:0] m, input logic [2:0] p);
    for (int c = 0; c < CH; c++)
      if (m[c]) rot[d][c*T +: T] = p;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic fwd_step(input int d, input logic [1:0] m);
    set_pat(d, m, 3'b110); hold(20);
    set_pat(d, m, 3'b011); hold(3);
    set_pat(d, m, 3'b101); hold(2);
    set_pat(d, m, 3'b111); hold(20);
  endtask

  task automatic bwd_step(input int d, input logic [1:0] m);
    set_pat(d, m, 3'b110); hold(20);
    set_pat(d, m, 3'b101); hold(3);
    set_pat(d, m, 3'b011); hold(2);
    set_pat(d, m, 3'b111); hold(20);
  endtask

  task automatic glitch(input int d, input logic [1:0] m);
    set_pat(d, m, 3'b110); hold(20);
    set_pat(d, m, 3'b011); hold(5);
    set_pat(d, m, 3'b111); hold(1);
    set_pat(d, m, 3'b011); hold(5);
    set_pat(d, m, 3'b111); hold(20);
  endtask

  task automatic cont_fwd(input int d, input logic [1:0] m);
    set_pat(d, m, 3'b110); hold(20);
    set_pat(d, m, 3'b011); hold(6);
    set_pat(d, m, 3'b101); hold(6);
    set_pat(d, m, 3'b110); hold(6);
    set_pat(d, m, 3'b011); hold(6);
    set_pat(d, m, 3'b101); hold(6);
    set_pat(d, m, 3'b111); hold(20);
  endtask

  task automatic cont_bwd(input int d, input logic [1:0] m);
    set_pat(d, m, 3'b110); hold(20);
    set_pat(d, m, 3'b101); hold(6);
    set_pat(d, m, 3'b011); hold(6);
    set_pat(d, m, 3'b110); hold(6);
    set_pat(d, m, 3'b111); hold(20);
  endtask

  // Pulse monitor: every inc/dec must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (inc[d][c] || dec[d][c]) begin
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_pulse dut%0d ch%0d: got inc=%0b dec=%0b cnt=%0d, expected no pulse",
                     d, c, inc[d][c], dec[d][c], cnt[d][c*W +: W]);
          end else begin
            e = sb.pop_front();
            if (e.d == d && e.ch == c && inc[d][c] == e.up && dec[d][c] == !e.up &&
                int'(cnt[d][c*W +: W]) == e.val)
              n_pass++;
            else
              $display("FAIL pulse dut%0d ch%0d: got inc=%0b dec=%0b cnt=%0d, expected dut%0d ch%0d inc=%0b dec=%0b cnt=%0d",
                       d, c, inc[d][c], dec[d][c], cnt[d][c*W +: W], e.d, e.ch, e.up, !e.up, e.val);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rot[d] = '1; ld[d] = 1'b0; ld_ch[d] = 1'b0; ld_val[d] = '0;
    end
    hold(3);
    rst = 1'b0;
    hold(100);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++)
        chk_cnt(d, c, 0, $sformatf("reset_cnt_dut%0d_ch%0d", d, c));

    // saturating instance
    push(0, 0, 1'b1, 1);  fwd_step(0, 2'b01);
    drain("a_fwd");
    chk_cnt(0, 1, 0, "a_ch1_untouched");
    push(0, 0, 1'b0, 0);  bwd_step(0, 2'b01);
    push(0, 0, 1'b0, 0);  bwd_step(0, 2'b01);
    drain("a_bwd_sat");
    glitch(0, 2'b01);
    drain("a_glitch");
    chk_cnt(0, 0, 0, "a_glitch_cnt");

    ld[0] = 1'b1; ld_ch[0] = 1'b1; ld_val[0] = 4'd15;
    hold(1);
    ld[0] = 1'b0;
    chk_cnt(0, 1, 11, "a_ld_clamp");

    set_pat(0, 2'b10, 3'b110); hold(20);
    set_pat(0, 2'b10, 3'b011); hold(3);
    set_pat(0, 2'b10, 3'b101); hold(2);
    ld[0] = 1'b1; ld_ch[0] = 1'b1; ld_val[0] = 4'd5;
    hold(1);
    ld[0] = 1'b0;
    chk_cnt(0, 1, 5, "a_ld_beats_commit");
    hold(2);
    set_pat(0, 2'b10, 3'b111); hold(20);
    drain("a_ld_no_pulse");
    chk_cnt(0, 1, 5, "a_ld_held");
    push(0, 1, 1'b1, 6);  fwd_step(0, 2'b10);
    drain("a_after_ld");

    // wrapping instance
    push(1, 0, 1'b0, 11); bwd_step(1, 2'b01);
    push(1, 0, 1'b1, 0);  push(1, 1, 1'b1, 1);  fwd_step(1, 2'b11);
    drain("b_wrap_dual");
    push(1, 1, 1'b1, 2);
    set_pat(1, 2'b10, 3'b110); hold(20);
    set_pat(1, 2'b10, 3'b011); hold(20);
    drain("b_slow");

    // accelerating instance
    push(2, 0, 1'b1, 1);  fwd_step(2, 2'b01);
    push(2, 0, 1'b1, 2);  fwd_step(2, 2'b01);
    drain("c_slow_steps");
    ld[2] = 1'b1; ld_ch[2] = 1'b0; ld_val[2] = 4'd4;
    hold(1);
    ld[2] = 1'b0;
    chk_cnt(2, 0, 4, "c_ld");
    push(2, 0, 1'b1, 5);  push(2, 0, 1'b1, 9);
    push(2, 0, 1'b1, 11); push(2, 0, 1'b1, 11);
    cont_fwd(2, 2'b01);
    drain("c_accel_fwd");
    push(2, 0, 1'b0, 10); push(2, 0, 1'b0, 6);
    cont_bwd(2, 2'b01);
    drain("c_accel_bwd");
    push(2, 1, 1'b1, 1);  fwd_step(2, 2'b10);
    drain("c_ch1");

    // reset in the middle of a partial step
    set_pat(0, 2'b01, 3'b110); hold(20);
    set_pat(0, 2'b01, 3'b011); hold(3);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++)
        chk_cnt(d, c, 0, $sformatf("midreset_cnt_dut%0d_ch%0d", d, c));
    set_pat(0, 2'b01, 3'b101); hold(2);
    set_pat(0, 2'b01, 3'b111); hold(20);
    drain("post_reset_quiet");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
